// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_t;

    // Width needed to count 0..max(a,b)-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rst_sync_core.sv
// Active-high reset synchroniser: asserts asynchronously, releases after NUM_STAGES edges.
module rst_sync_core #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic SYNC_RST
);

    logic [NUM_STAGES-1:0] chain;

    // Chain presets to ones on RST and shifts zeros in from stage 0 afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chain <= '1;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], 1'b0};
        end
    end

    assign SYNC_RST = chain[NUM_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises board reset, holds all channels, then frees them in index order.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST_REQ,
    output logic [NUM_CH-1:0] CH_RST,
    output logic              ALL_RDY
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int unsigned IDX_W = cnt_width(NUM_CH, 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    logic rst_s;

    rst_seq_state_t    state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [NUM_CH-1:0] ch_q, ch_nxt;
    logic              rdy_q, rdy_nxt;

    rst_sync_core #(
        .NUM_STAGES(NUM_STAGES)
    ) u_sync (
        .CLK     (CLK),
        .RST     (RST),
        .SYNC_RST(rst_s)
    );

    // State, counters and output registers; board reset clears them asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= HOLD;
            cnt   <= '0;
            idx   <= '0;
            ch_q  <= '1;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            ch_q  <= ch_nxt;
            rdy_q <= rdy_nxt;
        end
    end

    // Next-state logic; a synchronised reset or software request restarts the sequence first.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        ch_nxt    = ch_q;
        rdy_nxt   = rdy_q;

        if (rst_s || SW_RST_REQ) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            ch_nxt    = '1;
            rdy_nxt   = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt_nxt   = '0;
                        ch_nxt[0] = 1'b0;
                        if (NUM_CH == 1) begin
                            state_nxt = RUN;
                            rdy_nxt   = 1'b1;
                        end else begin
                            state_nxt = RELEASE;
                            idx_nxt   = IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nxt = '0;
                        idx_nxt = idx + 1'b1;
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (IDX_W'(i) == idx) begin
                                ch_nxt[i] = 1'b0;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            state_nxt = RUN;
                            rdy_nxt   = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_nxt = HOLD;
                end
            endcase
        end
    end

    assign CH_RST  = ch_q;
    assign ALL_RDY = rdy_q;

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset synchroniser and sequencer for the CREM top level. It takes the board reset, which is asynchronous and active-high, and synchronises its release into CLK through NUM_STAGES flops. It then holds all downstream blocks in reset for a programmable settle time and releases NUM_CH reset channels one at a time in index order, with a fixed gap between releases. A synchronous software reset request re-runs the full sequence without touching the board reset.

## Interface
Parameters:
- NUM_STAGES, 2, synchroniser depth; legal range ≥2.
- NUM_CH, 3, number of sequenced reset channels; legal range ≥1.
- HOLD_CYCLES, 16, cycles all channels stay asserted after the synchronised reset releases; legal range ≥1.
- GAP_CYCLES, 4, cycles between consecutive channel releases; legal range ≥1.

Ports:
- CLK  in  1  single clock.
- RST  in  1  asynchronous, active-high reset.
- SW_RST_REQ  in  1  synchronous level request; while high, the sequence restarts.
- CH_RST  out  NUM_CH  per-channel reset, active-high, registered.
- ALL_RDY  out  1  high once every channel is released, registered.

## Operation
- Synchroniser:
  - Asserting RST forces the whole chain to 1 immediately (asynchronously).
  - On release, 0 shifts in from stage 0; the internal signal rst_s falls after NUM_STAGES edges.
- FSM states:
  - HOLD: all channels asserted. Counter cnt counts edges while rst_s=0.
  - RELEASE: channels are freed one by one. Index idx tracks the next channel.
  - RUN: all channels free, ALL_RDY=1.
- Reset values (RST=1 or rst_s=1):
  - state=HOLD, cnt=0, idx=0.
  - CH_RST = all ones, ALL_RDY = 0.
  - RST assertion drives CH_RST high and ALL_RDY low asynchronously, in any state.
- HOLD:
  - Each edge with rst_s=0 increments cnt.
  - On the edge where cnt==HOLD_CYCLES-1: CH_RST[0]<=0, cnt<=0.
  - If NUM_CH==1: go to RUN and set ALL_RDY<=1 on that same edge. Otherwise go to RELEASE with idx<=1.
- RELEASE:
  - cnt increments each edge.
  - On the edge where cnt==GAP_CYCLES-1: CH_RST[idx]<=0, cnt<=0, idx<=idx+1.
  - When idx==NUM_CH-1, that same edge also moves to RUN and sets ALL_RDY<=1.
- RUN: outputs hold until RST or SW_RST_REQ.
- SW_RST_REQ, sampled at an edge with rst_s=0, in any state (including HOLD):
  - CH_RST<=all ones, ALL_RDY<=0, state<=HOLD, cnt<=0, idx<=0.
  - It has priority over any release that would occur on the same edge.
  - While held high, the block stays in HOLD with cnt=0.
  - It is ignored while rst_s=1.
- Channel release order is always 0 → NUM_CH-1. A released channel is never re-asserted except by RST or SW_RST_REQ.
- cnt width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)). Use 1 bit when the max is 1. cnt never wraps.

## Timing
- Edge numbering: e1 is the first rising edge sampling RST=0; en denotes the nth such edge.
- rst_s is low from edge e(NUM_STAGES).
- CH_RST[i] falls at edge e(NUM_STAGES+HOLD_CYCLES+i·GAP_CYCLES).
- ALL_RDY rises on the same edge that CH_RST[NUM_CH-1] falls.
- Defaults: CH_RST[0] falls at e18, CH_RST[1] at e22, CH_RST[2] at e26; ALL_RDY rises at e26.
- Software reset: SW_RST_REQ sampled high at edge s, low afterwards.
  - CH_RST asserts at s.
  - CH_RST[i] falls at s+HOLD_CYCLES+i·GAP_CYCLES.
- Reset is asserted asynchronously (zero-cycle latency); it is released only through the synchroniser.

## Structure
- Package rst_seq_pkg:
  - State typedef: HOLD=2'd0, RELEASE=2'd1, RUN=2'd2.
  - Constant function for cnt width.
- Sub-module rst_sync_core, parametrised by NUM_STAGES:
  - Active-high synchroniser, ports CLK, RST, SYNC_RST.
  - Chain reset value is all ones; SYNC_RST is driven by the last stage.
- The top level holds the FSM, cnt, idx and the output registers.

## Test plan
- Power-on with defaults: RST high for 5 cycles, then low. CH_RST = 3'b111 until e18; 3'b110 at e18, 3'b100 at e22, 3'b000 at e26; ALL_RDY=1 at e26.
- RST pulse mid-RELEASE (asserted between e20 and e21): CH_RST=3'b111 and ALL_RDY=0 immediately, before the next edge. After release, the full sequence repeats from e1.
- SW_RST_REQ 1-cycle pulse in RUN at edge s: CH_RST=3'b111 at s; CH_RST[0] falls at s+16, CH_RST[2] falls at s+24.
- SW_RST_REQ held high for 10 cycles during HOLD: CH_RST[0] falls 16 edges after the last edge sampling it high.
- NUM_CH=1, HOLD_CYCLES=1, NUM_STAGES=3: CH_RST and ALL_RDY toggle together at e4.
- SW_RST_REQ high while RST high: no effect. Release timing is identical to the power-on case.
